// File: rtl/counter_pkg.sv
// Shared types and constants for the counter observer: the snapshot record
// carried through the FIFO and the default queue depth.
package counter_pkg;

    localparam int CNT_W         = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic [CNT_W-1:0] delta;
        logic             wrap;
        logic             loaded;
    } snap_t;

endpackage

// File: rtl/snap_fifo.sv
// Synchronous FIFO of snapshot records. The head is read straight from storage
// and forced to zero while empty.
module snap_fifo
    import counter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  snap_t wdata,
    output snap_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    snap_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is still taken when the head leaves at the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is not reset; only the pointers and count are, and the empty
    // mask on rdata keeps stale contents from ever being observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/counter_reader.sv
// Observer beside the 8-bit loadable counter: tracks wrap/load history, builds
// tagged snapshots on request and queues them for a valid/ready consumer.
module counter_reader
    import counter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_data,
    input  logic             cnt_wr,
    input  logic             snap_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_value,
    output logic [CNT_W-1:0] out_delta,
    output logic             out_wrap,
    output logic             out_loaded,
    output logic             overflow,
    input  logic             ovf_clr
);

    logic [CNT_W-1:0] prev_data;
    logic             prev_wr;
    logic             hist_ok;
    logic [CNT_W-1:0] last_snap;
    logic             wrap_s;
    logic             load_s;

    logic             wrap_evt;
    logic             load_evt;
    logic             pop;
    logic             accept;
    logic             drop;
    logic             full;
    logic             empty;
    snap_t            entry;
    snap_t            head;

    // The counter shows a load one edge after cnt_wr, so a load to 00 is masked by prev_wr.
    assign wrap_evt = hist_ok && (prev_data == 8'hFF) && (cnt_data == 8'h00) && !prev_wr;
    assign load_evt = cnt_wr;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign accept    = snap_req && (!full || pop);
    assign drop      = snap_req && !accept;

    assign entry.value  = cnt_data;
    assign entry.delta  = cnt_data - last_snap;
    assign entry.wrap   = wrap_s | wrap_evt;
    assign entry.loaded = load_s | load_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_data <= '0;
            prev_wr   <= 1'b0;
            hist_ok   <= 1'b0;
            last_snap <= '0;
            wrap_s    <= 1'b0;
            load_s    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev_data <= cnt_data;
            prev_wr   <= cnt_wr;
            hist_ok   <= 1'b1;
            if (accept) begin
                last_snap <= cnt_data;
                wrap_s    <= 1'b0;
                load_s    <= 1'b0;
            end else begin
                // Dropped snapshots leave the history accumulating for the next accepted one.
                wrap_s <= wrap_s | wrap_evt;
                load_s <= load_s | load_evt;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    snap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata (entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign out_value  = head.value;
    assign out_delta  = head.delta;
    assign out_wrap   = head.wrap;
    assign out_loaded = head.loaded;

endmodule
